// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm-clock mode controller.
//   - state_e   : the six controller states
//   - CNT_W     : width of the timeout and auto-repeat counters
//   - TIMEOUT_HS_DEF / REPEAT_HS_DEF : default parameter values
//   - is_hour / is_min / is_edit : state classification helpers
package alarm_pkg;

  localparam int CNT_W          = 5;
  localparam int TIMEOUT_HS_DEF = 20;
  localparam int REPEAT_HS_DEF  = 3;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_A_VIEW = 3'd1,
    ST_T_HOUR = 3'd2,
    ST_T_MIN  = 3'd3,
    ST_A_HOUR = 3'd4,
    ST_A_MIN  = 3'd5
  } state_e;

  function automatic logic is_hour(state_e s);
    return (s == ST_T_HOUR) || (s == ST_A_HOUR);
  endfunction

  function automatic logic is_min(state_e s);
    return (s == ST_T_MIN) || (s == ST_A_MIN);
  endfunction

  function automatic logic is_edit(state_e s);
    return is_hour(s) || is_min(s);
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for one debounced button.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   level in  debounced button level
//   press out one-cycle pulse, high the cycle after the level is first seen high
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic level_q, level_d;
  logic press_q, press_d;

  always_comb begin
    level_d = level;
    press_d = level & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: mode/sequence controller for the alarm-clock set datapath.
// Turns debounced buttons into view/edit controls for the set register and
// commit pulses that write the edited value back to the time counter or the
// alarm register. Paced by the half-second tick.
//
// Optional feature: define ALARM_AUTOREPEAT_EN to auto-repeat increments while
// btn_incr is held in an hour/minute edit state.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   half_second         one-cycle tick every 0.5 s
//   btn_mode/set/incr   debounced button levels (press = rising edge)
//   show_time           set register tracks the time counter (RUN)
//   show_alarm          set register tracks the alarm register (A_VIEW)
//   incr_hour/minute    one-step increment pending, consumed on a half_second tick
//   commit_time/alarm   one-cycle load pulses for time counter / alarm register
//   alarm_en            alarm armed
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int TIMEOUT_HS = TIMEOUT_HS_DEF,
  parameter int REPEAT_HS  = REPEAT_HS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic half_second,
  input  logic btn_mode,
  input  logic btn_set,
  input  logic btn_incr,
  output logic show_time,
  output logic show_alarm,
  output logic incr_hour,
  output logic incr_minute,
  output logic commit_time,
  output logic commit_alarm,
  output logic alarm_en
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_HS - 1);

  logic press_mode, press_set, press_incr;

  btn_edge u_edge_mode (.clk(clk), .rst(rst), .level(btn_mode), .press(press_mode));
  btn_edge u_edge_set  (.clk(clk), .rst(rst), .level(btn_set),  .press(press_set));
  btn_edge u_edge_incr (.clk(clk), .rst(rst), .level(btn_incr), .press(press_incr));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             show_time_q, show_time_d;
  logic             show_alarm_q, show_alarm_d;
  logic             incr_hour_q, incr_hour_d;
  logic             incr_minute_q, incr_minute_d;
  logic             commit_time_q, commit_time_d;
  logic             commit_alarm_q, commit_alarm_d;
  logic             alarm_en_q, alarm_en_d;

  logic mode_win, set_win, incr_win, any_press, timeout;

`ifdef ALARM_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_HS);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`else
  logic unused_rep;
  assign unused_rep = btn_incr ^ (REPEAT_HS == 0);
`endif

  always_comb begin
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    alarm_en_d     = alarm_en_q;
    incr_hour_d    = incr_hour_q;
    incr_minute_d  = incr_minute_q;
    commit_time_d  = 1'b0;
    commit_alarm_d = 1'b0;
    timeout        = 1'b0;

    // Priority: mode beats set, set beats incr; losers are dropped.
    any_press = press_mode | press_set | press_incr;
    mode_win  = press_mode;
    set_win   = press_set & ~press_mode;
    incr_win  = press_incr & ~press_mode & ~press_set;

    // A pending step is consumed by the next tick; presses while pending are dropped.
    if (incr_hour_q) begin
      if (half_second) incr_hour_d = 1'b0;
    end else if (incr_win && is_hour(state_q)) begin
      incr_hour_d = 1'b1;
    end

    if (incr_minute_q) begin
      if (half_second) incr_minute_d = 1'b0;
    end else if (incr_win && is_min(state_q)) begin
      incr_minute_d = 1'b1;
    end

`ifdef ALARM_AUTOREPEAT_EN
    // Hold count saturates at REP_MAX; from then on every tick re-arms one step.
    rep_cnt_d = rep_cnt_q;
    if (is_edit(state_q) && btn_incr) begin
      if (half_second) begin
        if (rep_cnt_q == REP_MAX) begin
          if (is_hour(state_q)) incr_hour_d   = 1'b1;
          if (is_min(state_q))  incr_minute_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end else begin
      rep_cnt_d = '0;
    end
`endif

    // Inactivity timeout: only edges count as activity, so a held button does not.
    if (state_q == ST_RUN || any_press) begin
      to_cnt_d = '0;
    end else if (half_second) begin
      if (to_cnt_q == TO_LAST) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (timeout) begin
      state_d = ST_RUN;
    end else if (mode_win) begin
      state_d = (state_q == ST_RUN) ? ST_A_VIEW : ST_RUN;
    end else if (set_win) begin
      case (state_q)
        ST_RUN:    state_d = ST_T_HOUR;
        ST_A_VIEW: state_d = ST_A_HOUR;
        ST_T_HOUR: state_d = ST_T_MIN;
        ST_A_HOUR: state_d = ST_A_MIN;
        ST_T_MIN: begin
          state_d       = ST_RUN;
          commit_time_d = 1'b1;
        end
        ST_A_MIN: begin
          state_d        = ST_RUN;
          commit_alarm_d = 1'b1;
        end
        default:   state_d = ST_RUN;
      endcase
    end else if (incr_win && state_q == ST_A_VIEW) begin
      alarm_en_d = ~alarm_en_q;
    end

    // Any state change abandons an unconsumed step.
    if (state_d != state_q) begin
      incr_hour_d   = 1'b0;
      incr_minute_d = 1'b0;
    end

    show_time_d  = (state_d == ST_RUN);
    show_alarm_d = (state_d == ST_A_VIEW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      to_cnt_q       <= '0;
      show_time_q    <= 1'b1;
      show_alarm_q   <= 1'b0;
      incr_hour_q    <= 1'b0;
      incr_minute_q  <= 1'b0;
      commit_time_q  <= 1'b0;
      commit_alarm_q <= 1'b0;
      alarm_en_q     <= 1'b0;
`ifdef ALARM_AUTOREPEAT_EN
      rep_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      show_time_q    <= show_time_d;
      show_alarm_q   <= show_alarm_d;
      incr_hour_q    <= incr_hour_d;
      incr_minute_q  <= incr_minute_d;
      commit_time_q  <= commit_time_d;
      commit_alarm_q <= commit_alarm_d;
      alarm_en_q     <= alarm_en_d;
`ifdef ALARM_AUTOREPEAT_EN
      rep_cnt_q      <= rep_cnt_d;
`endif
    end
  end

  assign show_time    = show_time_q;
  assign show_alarm   = show_alarm_q;
  assign incr_hour    = incr_hour_q;
  assign incr_minute  = incr_minute_q;
  assign commit_time  = commit_time_q;
  assign commit_alarm = commit_alarm_q;
  assign alarm_en     = alarm_en_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Testbench for alarm_mode_ctrl: table-driven vectors, directed multi-cycle
// sequences and a randomized run compared against a behavioural model.
module tb_alarm_mode_ctrl;

  localparam int TIMEOUT = 20;
  localparam int REPEAT  = 3;
`ifdef ALARM_AUTOREPEAT_EN
  localparam int EXP_STEPS = 6;
`else
  localparam int EXP_STEPS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic half_second = 1'b0;
  logic btn_mode = 1'b0, btn_set = 1'b0, btn_incr = 1'b0;
  logic show_time, show_alarm, incr_hour, incr_minute;
  logic commit_time, commit_alarm, alarm_en;
  logic [6:0] outs;

  alarm_mode_ctrl dut (
    .clk(clk), .rst(rst), .half_second(half_second),
    .btn_mode(btn_mode), .btn_set(btn_set), .btn_incr(btn_incr),
    .show_time(show_time), .show_alarm(show_alarm),
    .incr_hour(incr_hour), .incr_minute(incr_minute),
    .commit_time(commit_time), .commit_alarm(commit_alarm),
    .alarm_en(alarm_en)
  );

  always #5 clk = ~clk;

  assign outs = {show_time, show_alarm, incr_hour, incr_minute, commit_time, commit_alarm, alarm_en};

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs %b, required %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // The controller is described as "where am I" flags: home, viewing the alarm,
  // or editing (which register, which field); one pending-step bit.
  bit   editing = 0, viewing = 0, edit_alarm = 0, edit_min = 0;
  bit   pend = 0, armed = 0, ct = 0, ca = 0;
  int   idle = 0, hold = 0;
  bit [2:0] prev = 0, prs = 0;
  logic [6:0] m_outs = 7'b1000000;

  always @(posedge clk) begin
    bit pm, ps, pi, any, np, timed_out, changed;
    if (rst) begin
      editing = 0; viewing = 0; edit_alarm = 0; edit_min = 0;
      pend = 0; armed = 0; ct = 0; ca = 0; idle = 0; hold = 0;
      prev = 0; prs = 0;
    end else begin
      pm = prs[2]; ps = prs[1]; pi = prs[0];
      any = pm | ps | pi;
      ct = 0; ca = 0;
      np = pend;
      if (pend) begin
        if (half_second) np = 0;
      end else if (editing && pi && !pm && !ps) begin
        np = 1;
      end
`ifdef ALARM_AUTOREPEAT_EN
      if (editing && btn_incr && half_second && hold >= REPEAT) np = 1;
      if (editing && btn_incr) begin
        if (half_second && hold < REPEAT) hold++;
      end else begin
        hold = 0;
      end
`endif
      timed_out = 0;
      if (!editing && !viewing) idle = 0;
      else if (any) idle = 0;
      else if (half_second) begin
        idle++;
        if (idle == TIMEOUT) begin
          timed_out = 1;
          idle = 0;
        end
      end
      changed = 0;
      if (timed_out) begin
        editing = 0; viewing = 0; changed = 1;
      end else if (pm) begin
        if (editing || viewing) begin editing = 0; viewing = 0; end
        else viewing = 1;
        changed = 1;
      end else if (ps) begin
        if (editing) begin
          if (!edit_min) edit_min = 1;
          else begin
            if (edit_alarm) ca = 1; else ct = 1;
            editing = 0;
          end
        end else begin
          edit_alarm = viewing; edit_min = 0; editing = 1; viewing = 0;
        end
        changed = 1;
      end else if (pi && viewing) begin
        armed = !armed;
      end
      if (changed) np = 0;
      pend = np;
      prs = {btn_mode, btn_set, btn_incr} & ~prev;
      prev = {btn_mode, btn_set, btn_incr};
    end
    m_outs = {!editing && !viewing, viewing, pend && editing && !edit_min,
              pend && editing && edit_min, ct, ca, armed};
  end

  // ---------------- Event counters ----------------
  int n_ihour_rise = 0, n_imin_rise = 0, n_ct = 0, n_ca = 0, n_steps = 0;
  logic prev_ih = 0, prev_im = 0;

  always @(negedge clk) begin
    #1;
    if (incr_hour && !prev_ih) n_ihour_rise++;
    if (incr_minute && !prev_im) n_imin_rise++;
    if (commit_time) n_ct++;
    if (commit_alarm) n_ca++;
    if (incr_hour && half_second) n_steps++;
    prev_ih = incr_hour;
    prev_im = incr_minute;
  end

  task automatic clr_cnt();
    n_ihour_rise = 0; n_imin_rise = 0; n_ct = 0; n_ca = 0; n_steps = 0;
  endtask

  // Drive a one-cycle press and wait until the controller has acted on it.
  task automatic press(input bit m, input bit s, input bit i);
    btn_mode = m; btn_set = s; btn_incr = i;
    @(negedge clk);
    btn_mode = 0; btn_set = 0; btn_incr = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    half_second = 1;
    @(negedge clk);
    half_second = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    logic m, s, i, hs;
    logic [6:0] exp;  // {show_time, show_alarm, incr_hour, incr_minute, commit_time, commit_alarm, alarm_en}
  } vec_t;
  vec_t vtab[17];

  initial begin
    vtab[0]  = '{0, 1, 0, 0, 7'b1000000};
    vtab[1]  = '{0, 0, 0, 0, 7'b0000000};  // -> T_HOUR
    vtab[2]  = '{0, 0, 1, 0, 7'b0000000};
    vtab[3]  = '{0, 0, 0, 0, 7'b0010000};  // hour step pending
    vtab[4]  = '{0, 0, 0, 0, 7'b0010000};  // held until a tick
    vtab[5]  = '{0, 0, 0, 1, 7'b0000000};  // consumed
    vtab[6]  = '{0, 1, 0, 0, 7'b0000000};
    vtab[7]  = '{0, 0, 0, 0, 7'b0000000};  // -> T_MIN
    vtab[8]  = '{0, 1, 0, 0, 7'b0000000};
    vtab[9]  = '{0, 0, 0, 0, 7'b1000100};  // commit_time, RUN
    vtab[10] = '{0, 0, 0, 0, 7'b1000000};  // pulse lasts one cycle
    vtab[11] = '{1, 1, 0, 0, 7'b1000000};  // mode+set together
    vtab[12] = '{0, 0, 0, 0, 7'b0100000};  // mode wins -> A_VIEW
    vtab[13] = '{0, 0, 1, 0, 7'b0100000};
    vtab[14] = '{0, 0, 0, 0, 7'b0100001};  // alarm armed
    vtab[15] = '{1, 0, 0, 0, 7'b0100001};
    vtab[16] = '{0, 0, 0, 0, 7'b1000001};  // back to RUN

    // Reset
    @(negedge clk);
    check("reset_hold", outs, 7'b1000000);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_release", outs, 7'b1000000);

    for (int k = 0; k < 17; k++) begin
      btn_mode = vtab[k].m; btn_set = vtab[k].s;
      btn_incr = vtab[k].i; half_second = vtab[k].hs;
      @(negedge clk);
      check($sformatf("vec%0d", k), outs, vtab[k].exp);
    end

    // Edit alarm: three spaced minute steps then commit
    clr_cnt();
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      press(0, 0, 1);
      tick();
    end
    press(0, 1, 0);
    check_int("alarm_min_steps", n_imin_rise, 3);
    check_int("alarm_commit", n_ca, 1);
    check_int("alarm_no_time_commit", n_ct, 0);
    check("alarm_end_run", outs, 7'b1000001);

    // Simultaneous presses
    clr_cnt();
    press(1, 1, 0);
    check("mode_beats_set", outs, 7'b0100001);
    press(1, 0, 0);
    press(0, 1, 0);
    check("enter_t_hour", outs, 7'b0000001);
    press(0, 1, 1);
    check_int("set_beats_incr", n_ihour_rise, 0);
    press(0, 0, 1);
    check("in_t_min", outs, 7'b0001001);
    press(1, 0, 0);
    check("abort_t_min", outs, 7'b1000001);
    check_int("abort_no_commit", n_ct, 0);

    // Timeout in A_HOUR, restarted by a press after 19 ticks
    clr_cnt();
    press(1, 0, 0);
    press(0, 1, 0);
    repeat (19) tick();
    check("to_19_still_edit", outs, 7'b0000001);
    press(0, 0, 1);
    check("to_press_step", outs, 7'b0010001);
    repeat (19) tick();
    check("to_restarted", outs, 7'b0000001);
    half_second = 1;
    @(negedge clk);
    half_second = 0;
    check("to_tick20_run", outs, 7'b1000001);
    @(negedge clk);
    check_int("to_no_commit", n_ct + n_ca, 0);

    // Reset mid-edit
    clr_cnt();
    press(0, 1, 0);
    press(0, 0, 1);
    check("pre_rst_edit", outs, 7'b0010001);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_edit", outs, 7'b1000000);
    @(negedge clk);
    check_int("rst_no_commit", n_ct + n_ca, 0);

    // Held increment in T_HOUR
    press(0, 1, 0);
    clr_cnt();
    btn_incr = 1;
    repeat (3) @(negedge clk);
    repeat (8) tick();
    btn_incr = 0;
    repeat (2) tick();
    check_int("hold_steps", n_steps, EXP_STEPS);
    press(1, 0, 0);
    check("hold_exit", outs, 7'b1000000);

    // Randomized run against the model; alternate busy and quiet phases
    for (int c = 0; c < 4000; c++) begin
      int den;
      @(negedge clk);
      check("rand", outs, m_outs);
      den = ((c / 500) % 2 == 1) ? 300 : 12;
      if ($urandom_range(0, den - 1) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, den - 1) == 0) btn_set  = ~btn_set;
      if ($urandom_range(0, den - 1) == 0) btn_incr = ~btn_incr;
      half_second = ($urandom_range(0, (den == 12) ? 7 : 2) == 0);
      rst = ($urandom_range(0, 799) == 0);
    end
    rst = 0;
    @(negedge clk);
    check("rand_final", outs, m_outs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
